// File: rtl/code_lock_ctrl.sv
// Keypad code lock: 4-digit entry check, timed unlock window,
// failure lockout and in-window code reprogramming.
module code_lock_ctrl #(
  parameter logic [15:0] DEFAULT_CODE   = 16'h1094,
  parameter int          MAX_FAILS      = 3,
  parameter int          UNLOCK_CYCLES  = 8,
  parameter int          LOCKOUT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       digit_valid,
  input  logic [3:0] digit,
  input  logic       abort,
  input  logic       prog_en,
  output logic       unlocked,
  output logic       locked_out,
  output logic [2:0] fail_cnt,
  output logic       match_pulse,
  output logic       fail_pulse,
  output logic       code_updated
);

  localparam int TMAX = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ?
                        UNLOCK_CYCLES : LOCKOUT_CYCLES;
  localparam int TW = $clog2(TMAX + 1);
  localparam logic [TW-1:0] UL = TW'(UNLOCK_CYCLES);
  localparam logic [TW-1:0] LO = TW'(LOCKOUT_CYCLES);
  localparam logic [2:0] MF  = 3'(MAX_FAILS);
  localparam logic [2:0] MF1 = 3'(MAX_FAILS - 1);

  typedef enum logic [1:0] {
    ENTRY, CHECK, OPEN, LOCKOUT
  } state_t;

  state_t        state, state_n;
  logic [TW-1:0] timer, timer_n;
  logic [15:0]   ent_buf, ent_buf_n;
  logic [1:0]    ent_cnt, ent_cnt_n;
  logic [15:0]   prg_buf, prg_buf_n;
  logic [1:0]    prg_cnt, prg_cnt_n;
  logic [15:0]   code, code_n;
  logic [2:0]    fail_n;
  logic          match_n, failp_n, upd_n;
  logic          prog_dig;

  assign prog_dig = digit_valid && prog_en && !abort;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ENTRY;
      timer        <= '0;
      ent_buf      <= '0;
      ent_cnt      <= '0;
      prg_buf      <= '0;
      prg_cnt      <= '0;
      code         <= DEFAULT_CODE;
      fail_cnt     <= '0;
      match_pulse  <= 1'b0;
      fail_pulse   <= 1'b0;
      code_updated <= 1'b0;
      unlocked     <= 1'b0;
      locked_out   <= 1'b0;
    end else begin
      state        <= state_n;
      timer        <= timer_n;
      ent_buf      <= ent_buf_n;
      ent_cnt      <= ent_cnt_n;
      prg_buf      <= prg_buf_n;
      prg_cnt      <= prg_cnt_n;
      code         <= code_n;
      fail_cnt     <= fail_n;
      match_pulse  <= match_n;
      fail_pulse   <= failp_n;
      code_updated <= upd_n;
      unlocked     <= (state_n == OPEN);
      locked_out   <= (state_n == LOCKOUT);
    end
  end

  always_comb begin
    state_n   = state;
    timer_n   = timer;
    ent_buf_n = ent_buf;
    ent_cnt_n = ent_cnt;
    prg_buf_n = prg_buf;
    prg_cnt_n = prg_cnt;
    code_n    = code;
    fail_n    = fail_cnt;
    match_n   = 1'b0;
    failp_n   = 1'b0;
    upd_n     = 1'b0;
    unique case (state)
      ENTRY: begin
        if (abort) begin
          ent_cnt_n = '0;
        end else if (digit_valid) begin
          ent_buf_n = {ent_buf[11:0], digit};
          if (ent_cnt == 2'd3) begin
            ent_cnt_n = '0;
            state_n   = CHECK;
          end else begin
            ent_cnt_n = ent_cnt + 2'd1;
          end
        end
      end
      CHECK: begin
        if (ent_buf == code) begin
          match_n   = 1'b1;
          fail_n    = '0;
          timer_n   = UL;
          prg_cnt_n = '0;
          state_n   = OPEN;
        end else begin
          failp_n = 1'b1;
          if (fail_cnt >= MF1) begin
            fail_n  = MF;
            timer_n = LO;
            state_n = LOCKOUT;
          end else begin
            fail_n  = fail_cnt + 3'd1;
            state_n = ENTRY;
          end
        end
      end
      OPEN: begin
        if (!prog_en || abort)
          prg_cnt_n = '0;
        // A program digit restarts the window, so it also beats timeout
        if (prog_dig) begin
          timer_n   = UL;
          prg_buf_n = {prg_buf[11:0], digit};
          if (prg_cnt == 2'd3) begin
            code_n    = {prg_buf[11:0], digit};
            upd_n     = 1'b1;
            prg_cnt_n = '0;
          end else begin
            prg_cnt_n = prg_cnt + 2'd1;
          end
        end else if (timer <= TW'(1)) begin
          timer_n   = '0;
          prg_cnt_n = '0;
          state_n   = ENTRY;
        end else begin
          timer_n = timer - TW'(1);
        end
      end
      LOCKOUT: begin
        if (timer <= TW'(1)) begin
          timer_n   = '0;
          fail_n    = '0;
          ent_cnt_n = '0;
          state_n   = ENTRY;
        end else begin
          timer_n = timer - TW'(1);
        end
      end
      default: state_n = ENTRY;
    endcase
  end

endmodule

// File: doc/code_lock_ctrl.md
# code_lock_ctrl

Controller that sequences a 4-digit keypad code check around a programmable code register. It accepts BCD digit strobes, collects them into a 4-digit entry, compares against the stored code, and grants a timed unlock window. It counts consecutive failures and enforces a timed lockout. While unlocked, it allows the code to be reprogrammed. It sits between the keypad digit source and the door/actuator logic, alongside the fixed-pattern digit detectors.

## Interface
- DEFAULT_CODE, 16'h1094: code loaded at reset, four 4-bit digits, first-entered digit in [15:12].
- MAX_FAILS, 3: consecutive failed checks that trigger lockout (1..7).
- UNLOCK_CYCLES, 8: length of the unlock window in clocks (≥2).
- LOCKOUT_CYCLES, 16: length of the lockout in clocks (≥2).
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- digit_valid  input  1  one digit presented this cycle.
- digit  input  4  digit value 0–9; values 10–15 are accepted and compared like any other value.
- abort  input  1  discard a partial entry.
- prog_en  input  1  while unlocked, route digits to code reprogramming instead of being ignored.
- unlocked  output  1  high during the unlock window.
- locked_out  output  1  high during lockout.
- fail_cnt  output  3  consecutive failed checks.
- match_pulse  output  1  one-cycle pulse when a check succeeds.
- fail_pulse  output  1  one-cycle pulse when a check fails.
- code_updated  output  1  one-cycle pulse when a new code is committed.

## Operation
- States: ENTRY, CHECK, OPEN, LOCKOUT. All outputs are registered.
- Reset:
  - state=ENTRY, code=DEFAULT_CODE, entry buffer=0, entry count=0, fail_cnt=0, timers=0.
  - All outputs low.
- ENTRY:
  - Each digit_valid shifts digit into the 16-bit entry buffer (left shift, new digit in [3:0]) and increments the entry count.
  - On the 4th digit, go to CHECK and clear the entry count.
  - abort clears the entry count; the buffer contents are don't-care.
  - If abort and digit_valid occur in the same cycle, abort wins and the digit is dropped.
- CHECK (exactly 1 cycle; digit_valid ignored):
  - On buffer==code: match_pulse=1, fail_cnt←0, load the unlock timer with UNLOCK_CYCLES, go to OPEN.
  - On mismatch: fail_pulse=1, fail_cnt←fail_cnt+1.
    - If the new count equals MAX_FAILS, load the lockout timer with LOCKOUT_CYCLES and go to LOCKOUT.
    - Otherwise go to ENTRY.
- OPEN:
  - unlocked=1. The timer decrements each cycle; when it reaches 0, go to ENTRY.
  - With prog_en=0, digits are ignored.
  - With prog_en=1, each digit shifts into a separate program buffer, increments a program count, and reloads the timer to UNLOCK_CYCLES.
  - On the 4th program digit, code←program buffer, code_updated=1 for one cycle, program count←0, and the state stays OPEN.
  - abort, or prog_en falling mid-programming, clears the program count. The code is unchanged.
  - A timeout mid-programming discards the partial program; the code is unchanged.
- LOCKOUT:
  - locked_out=1. Digits and abort are ignored.
  - The timer decrements each cycle. At 0: fail_cnt←0, entry count←0, go to ENTRY.
- fail_cnt saturates at MAX_FAILS and is cleared only by a match, lockout expiry, or rst.
- rst in any state, including mid-entry, OPEN, or LOCKOUT, returns to reset values on the next edge. Any reprogrammed code is lost.

## Timing
- 4th entry digit sampled at edge t → CHECK at t+1.
- Outcome signals at t+2, all at the same edge:
  - unlocked or locked_out asserts.
  - match_pulse/fail_pulse asserts for one cycle.
  - fail_cnt updates.
- unlocked stays high for exactly UNLOCK_CYCLES cycles without reprogramming activity. A program digit restarts the full window from the following cycle.
- locked_out stays high for exactly LOCKOUT_CYCLES cycles, then ENTRY accepts digits on the first cycle after it falls.
- code_updated goes high the cycle after the 4th program digit. The new code applies to the next entry.
- Back-to-back digit_valid on consecutive cycles is supported in ENTRY and OPEN. There is no ready/backpressure.

## Test plan
- Reset, then digits 1,0,9,4 on consecutive cycles → match_pulse at 4th digit+2, unlocked high 8 cycles, fail_cnt=0.
- Three wrong entries (e.g. 1,0,9,5) → fail_cnt 1,2,3. Third fail_pulse coincides with locked_out rising; locked_out lasts 16 cycles; digits sent during lockout are ignored; fail_cnt=0 afterwards.
- Two fails, then the correct code → fail_cnt returns to 0 on match. A later single fail gives fail_cnt=1, not lockout.
- Unlock, prog_en=1, digits 7,3,3,2 → code_updated pulse. After timeout, 1,0,9,4 fails and 7,3,3,2 unlocks.
- Partial entry 1,0 then abort, then 1,0,9,4 → match. Also, abort and digit in the same cycle → digit dropped.
- rst asserted in OPEN after reprogramming → unlocked=0 next cycle, and DEFAULT_CODE 1,0,9,4 unlocks again.
